lsm_addr_gen: RTL and testbench

//  Address/sequence generator for ARM LDM/STM. Consumes the register list (IR[15:0]), P/U bits and base value.

---
 rtl/lsm_pkg.sv | 20 ++
 rtl/lsm_prio_enc.sv | 16 +
 rtl/lsm_addr_gen.sv | 145 ++++++++++++++
 tb/tb_lsm_addr_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_pkg.sv
// Shared types for the load/store-multiple address generator: FSM states,
// addressing-mode encodings and the default per-register address step.
package lsm_pkg;
  localparam int LSM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } lsm_state_t;

  // Encoded as {P,U} straight from IR[24:23]
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } lsm_mode_t;
endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder over a 16-entry register list.
// Also used by the LSM manager to pick the next register.
module lsm_prio_enc (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        any
);
  // Scan downwards so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--)
      if (vec[i]) idx = 4'(i);
  end

  assign any = |vec;
endmodule

// File: rtl/lsm_addr_gen.sv
// LDM/STM address and register sequencer: one (address, register) pair per
// transfer plus base writeback. Optional LSM_ALIGN_CHECK_EN faults on a misaligned base.
module lsm_addr_gen
  import lsm_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = LSM_WORD_BYTES,
  parameter int NREGS      = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [NREGS-1:0]  REG_LIST,
  input  logic              P,
  input  logic              U,
  input  logic              MOC,
  output logic [ADDR_W-1:0] MAR_ADDR,
  output logic [3:0]        REG_ADDR,
  output logic              XFER_VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] WB_VALUE,
  output logic              ALIGN_FAULT
);
  localparam int CNT_W = $clog2(NREGS + 1);

  lsm_state_t        state;
  lsm_mode_t         mode_q;
  logic [NREGS-1:0]  list_q, list_nxt, enc_in;
  logic [ADDR_W-1:0] base_q, addr_q, wb_q, base_in;
  logic [ADDR_W-1:0] span, step, s_addr, w_addr;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        enc_idx;
  logic              enc_any, misalign;

  // Drop the lowest set bit: the list as it will be after this transfer
  assign list_nxt = list_q & (list_q - 1'b1);
  assign enc_in   = (state == ST_CALC) ? list_q : list_nxt;

  lsm_prio_enc u_prio (
    .vec (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt = cnt + CNT_W'(list_q[i]);
  end

  assign step = ADDR_W'(WORD_BYTES);
  assign span = ADDR_W'(cnt) * step;

  always_comb begin
    s_addr = base_q;
    w_addr = base_q + span;
    case (mode_q)
      MODE_IA: begin s_addr = base_q;               w_addr = base_q + span; end
      MODE_IB: begin s_addr = base_q + step;        w_addr = base_q + span; end
      MODE_DA: begin s_addr = base_q - span + step; w_addr = base_q - span; end
      MODE_DB: begin s_addr = base_q - span;        w_addr = base_q - span; end
      default: ;
    endcase
  end

`ifdef LSM_ALIGN_CHECK_EN
  assign base_in  = BASE;
  assign misalign = |base_q[1:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ALIGN_FAULT <= 1'b0;
    else          ALIGN_FAULT <= (state == ST_CALC) && misalign;
  end
`else
  // Without the check, a misaligned base is silently rounded down
  assign base_in     = {BASE[ADDR_W-1:2], 2'b00};
  assign misalign    = 1'b0;
  assign ALIGN_FAULT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_DA;
      list_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      wb_q       <= '0;
      MAR_ADDR   <= '0;
      REG_ADDR   <= '0;
      XFER_VALID <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      WB_VALUE   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: if (START) begin
          base_q <= base_in;
          list_q <= REG_LIST;
          mode_q <= lsm_mode_t'({P, U});
          BUSY   <= 1'b1;
          state  <= ST_CALC;
        end
        ST_CALC: begin
          if (misalign) begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else if (!enc_any) begin
            DONE     <= 1'b1;
            WB_VALUE <= w_addr;
            state    <= ST_DONE;
          end else begin
            addr_q     <= s_addr;
            wb_q       <= w_addr;
            MAR_ADDR   <= s_addr;
            REG_ADDR   <= enc_idx;
            XFER_VALID <= 1'b1;
            state      <= ST_XFER;
          end
        end
        ST_XFER: if (MOC) begin
          list_q   <= list_nxt;
          addr_q   <= addr_q + step;
          MAR_ADDR <= addr_q + step;
          if (enc_any) begin
            REG_ADDR <= enc_idx;
          end else begin
            XFER_VALID <= 1'b0;
            DONE       <= 1'b1;
            WB_VALUE   <= wb_q;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsm_addr_gen.sv
// Directed bench for lsm_addr_gen: addressing modes, stall, empty list,
// reset abort, wrap and base alignment handling.
module tb_lsm_addr_gen;
  logic        CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, P = 1'b0, U = 1'b0, MOC = 1'b0;
  logic [31:0] BASE = '0;
  logic [15:0] REG_LIST = '0;
  logic [31:0] MAR_ADDR, WB_VALUE;
  logic [3:0]  REG_ADDR;
  logic        XFER_VALID, BUSY, DONE, ALIGN_FAULT;

  int tests = 0, fails = 0;
  logic [31:0] ca [16];
  logic [3:0]  cr [16];
  int          cn, first_xv, done_cyc, done_w, af_seen;
  logic [31:0] cwb;

  lsm_addr_gen dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .BASE(BASE), .REG_LIST(REG_LIST),
    .P(P), .U(U), .MOC(MOC), .MAR_ADDR(MAR_ADDR), .REG_ADDR(REG_ADDR),
    .XFER_VALID(XFER_VALID), .BUSY(BUSY), .DONE(DONE), .WB_VALUE(WB_VALUE),
    .ALIGN_FAULT(ALIGN_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic do_start(input logic [31:0] b, input logic [15:0] l, input logic p, input logic u);
    @(negedge CLK);
    BASE = b; REG_LIST = l; P = p; U = u; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Records every transfer seen at negedges k=1.. after the START edge
  task automatic collect();
    cn = 0; first_xv = 0; done_cyc = 0; done_w = 0; af_seen = 0; cwb = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (ALIGN_FAULT) af_seen++;
      if (XFER_VALID) begin
        if (cn == 0) first_xv = k;
        if (cn < 16) begin ca[cn] = MAR_ADDR; cr[cn] = REG_ADDR; end
        cn++;
      end
      if (DONE) begin
        done_cyc = k; cwb = WB_VALUE;
        @(negedge CLK);
        done_w = (DONE || BUSY) ? 2 : 1;
        break;
      end
      if (!BUSY && k >= 2) break;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if ({MAR_ADDR, REG_ADDR, XFER_VALID, BUSY, DONE, WB_VALUE, ALIGN_FAULT} !== '0) begin
      fails++; $display("FAIL reset_outs: got %h %h %b%b%b %h %b want all zero",
        MAR_ADDR, REG_ADDR, XFER_VALID, BUSY, DONE, WB_VALUE, ALIGN_FAULT);
    end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b want 0", BUSY); end
  endtask

  task automatic test_ia();
    MOC = 1'b1;
    do_start(32'h100, 16'h000F, 1'b0, 1'b1);
    collect();
    tests++;
    if (cn != 4) begin fails++; $display("FAIL ia_count: got %0d want 4", cn); end
    tests++;
    if (first_xv != 2) begin fails++; $display("FAIL ia_latency: got %0d want 2", first_xv); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ca[i] !== 32'h100 + 32'(4 * i) || cr[i] !== 4'(i)) begin
        fails++; $display("FAIL ia_xfer%0d: got (%h,R%0d) want (%h,R%0d)", i, ca[i], cr[i], 32'h100 + 32'(4 * i), i);
      end
    end
    tests++;
    if (cwb !== 32'h110) begin fails++; $display("FAIL ia_wb: got %h want 00000110", cwb); end
    tests++;
    if (done_cyc != 6 || done_w != 1) begin
      fails++; $display("FAIL ia_done: at %0d width %0d want at 6 width 1", done_cyc, done_w);
    end
  endtask

  task automatic test_db();
    MOC = 1'b1;
    do_start(32'h200, 16'h8001, 1'b1, 1'b0);
    collect();
    tests++;
    if (cn != 2 || ca[0] !== 32'h1F8 || cr[0] !== 4'd0 || ca[1] !== 32'h1FC || cr[1] !== 4'd15) begin
      fails++; $display("FAIL db_xfers: n=%0d (%h,R%0d)(%h,R%0d) want 2 (1f8,R0)(1fc,R15)",
        cn, ca[0], cr[0], ca[1], cr[1]);
    end
    tests++;
    if (cwb !== 32'h1F8) begin fails++; $display("FAIL db_wb: got %h want 000001f8", cwb); end
  endtask

  task automatic test_ib_da();
    MOC = 1'b1;
    do_start(32'h100, 16'h0010, 1'b1, 1'b1);
    collect();
    tests++;
    if (cn != 1 || ca[0] !== 32'h104 || cr[0] !== 4'd4 || cwb !== 32'h104) begin
      fails++; $display("FAIL ib: n=%0d (%h,R%0d) wb=%h want 1 (104,R4) wb=104", cn, ca[0], cr[0], cwb);
    end
    do_start(32'h100, 16'h0003, 1'b0, 1'b0);
    collect();
    tests++;
    if (cn != 2 || ca[0] !== 32'hFC || cr[0] !== 4'd0 || ca[1] !== 32'h100 || cr[1] !== 4'd1) begin
      fails++; $display("FAIL da_xfers: n=%0d (%h,R%0d)(%h,R%0d) want 2 (fc,R0)(100,R1)",
        cn, ca[0], cr[0], ca[1], cr[1]);
    end
    tests++;
    if (cwb !== 32'hF8) begin fails++; $display("FAIL da_wb: got %h want 000000f8", cwb); end
  endtask

  task automatic test_stall();
    MOC = 1'b1;
    do_start(32'h100, 16'h000F, 1'b0, 1'b1);
    @(negedge CLK);                      // k1: CALC
    @(negedge CLK);                      // k2: R0 consumed at next edge
    @(negedge CLK);                      // k3: R1 presented, then stalled
    tests++;
    if (XFER_VALID !== 1'b1 || MAR_ADDR !== 32'h104 || REG_ADDR !== 4'd1) begin
      fails++; $display("FAIL stall_pre: v=%b (%h,R%0d) want 1 (104,R1)", XFER_VALID, MAR_ADDR, REG_ADDR);
    end
    MOC = 1'b0; START = 1'b1; BASE = 32'h300; REG_LIST = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests++;
      if (XFER_VALID !== 1'b1 || MAR_ADDR !== 32'h104 || REG_ADDR !== 4'd1) begin
        fails++; $display("FAIL stall_hold%0d: v=%b (%h,R%0d) want 1 (104,R1)", k, XFER_VALID, MAR_ADDR, REG_ADDR);
      end
    end
    MOC = 1'b1; START = 1'b0;
    @(negedge CLK);
    tests++;
    if (MAR_ADDR !== 32'h108 || REG_ADDR !== 4'd2) begin
      fails++; $display("FAIL stall_resume2: (%h,R%0d) want (108,R2)", MAR_ADDR, REG_ADDR);
    end
    @(negedge CLK);
    tests++;
    if (MAR_ADDR !== 32'h10C || REG_ADDR !== 4'd3) begin
      fails++; $display("FAIL stall_resume3: (%h,R%0d) want (10c,R3)", MAR_ADDR, REG_ADDR);
    end
    @(negedge CLK);
    tests++;
    if (DONE !== 1'b1 || WB_VALUE !== 32'h110 || XFER_VALID !== 1'b0) begin
      fails++; $display("FAIL stall_done: done=%b wb=%h v=%b want 1 110 0", DONE, WB_VALUE, XFER_VALID);
    end
    @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      fails++; $display("FAIL stall_idle: busy=%b done=%b want 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_empty();
    MOC = 1'b1;
    do_start(32'h40, 16'h0000, 1'b0, 1'b1);
    collect();
    tests++;
    if (cn != 0 || done_cyc != 2 || cwb !== 32'h40) begin
      fails++; $display("FAIL empty: n=%0d done_at=%0d wb=%h want 0 2 40", cn, done_cyc, cwb);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    MOC = 1'b1;
    do_start(32'h100, 16'hFFFF, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    tests++;
    if (XFER_VALID !== 1'b1) begin fails++; $display("FAIL rmid_active: v=%b want 1", XFER_VALID); end
    RESET_N = 1'b0;
    #1;
    tests++;
    if ({MAR_ADDR, REG_ADDR, XFER_VALID, BUSY, DONE, WB_VALUE, ALIGN_FAULT} !== '0) begin
      fails++; $display("FAIL rmid_outs: got %h %h %b%b%b %h want all zero",
        MAR_ADDR, REG_ADDR, XFER_VALID, BUSY, DONE, WB_VALUE);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    ndone = 0;
    repeat (20) begin @(negedge CLK); if (DONE || BUSY) ndone++; end
    tests++;
    if (ndone != 0) begin fails++; $display("FAIL rmid_abort: active cycles=%0d want 0", ndone); end
  endtask

  task automatic test_wrap();
    MOC = 1'b1;
    do_start(32'h0, 16'h0001, 1'b1, 1'b0);
    collect();
    tests++;
    if (cn != 1 || ca[0] !== 32'hFFFF_FFFC || cr[0] !== 4'd0 || cwb !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap: n=%0d (%h,R%0d) wb=%h want 1 (fffffffc,R0) wb=fffffffc", cn, ca[0], cr[0], cwb);
    end
  endtask

  task automatic test_align();
    MOC = 1'b1;
    do_start(32'h102, 16'h0003, 1'b0, 1'b1);
    collect();
`ifdef LSM_ALIGN_CHECK_EN
    tests++;
    if (af_seen != 1 || cn != 0 || done_cyc != 0) begin
      fails++; $display("FAIL align_fault: af=%0d n=%0d done_at=%0d want 1 0 0", af_seen, cn, done_cyc);
    end
    tests++;
    if (WB_VALUE !== 32'hFFFF_FFFC) begin fails++; $display("FAIL align_wb: got %h want fffffffc", WB_VALUE); end
`else
    tests++;
    if (af_seen != 0 || cn != 2 || ca[0] !== 32'h100 || ca[1] !== 32'h104) begin
      fails++; $display("FAIL align_round: af=%0d n=%0d %h %h want 0 2 100 104", af_seen, cn, ca[0], ca[1]);
    end
    tests++;
    if (cwb !== 32'h108) begin fails++; $display("FAIL align_wb: got %h want 00000108", cwb); end
`endif
  endtask

  initial begin
    test_reset();
    test_ia();
    test_db();
    test_ib_da();
    test_stall();
    test_empty();
    test_reset_mid();
    test_wrap();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
